// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - measures samples spanned by n_periods tone periods from dual-sample input
module tone_period_meter #(
  parameter int W_CNT  = 24,
  parameter int W_NPER = 8
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              enable,
  input  logic              samp0,
  input  logic              samp1,
  input  logic [W_NPER-1:0] n_periods,
  output logic [W_CNT-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic              timeout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [W_CNT-1:0]  CNT_ONE   = W_CNT'(1);
  localparam logic [W_CNT-1:0]  CNT_TWO   = W_CNT'(2);
  localparam logic [W_CNT-1:0]  CNT_LIMIT = {{(W_CNT-1){1'b1}}, 1'b0};
  localparam logic [W_NPER-1:0] NPER_ONE  = W_NPER'(1);

  state_t            state, state_next;
  logic              prev;
  logic [W_CNT-1:0]  cnt, cnt_next;
  logic [W_NPER-1:0] ecnt, ecnt_next;
  logic [W_NPER-1:0] nper, nper_next;
  logic              timeout_next;
  logic              capture;

  logic              edge0, edge1, edge_any;
  logic [W_CNT-1:0]  restart;
  logic [W_CNT-1:0]  measured;
  logic [W_NPER-1:0] n_eff;
  logic [W_NPER-1:0] ecnt_inc;

  // An edge between the previous pair and samp0 lands at p=0; between samp0 and samp1 at p=1.
  assign edge0    = !prev && samp0;
  assign edge1    = !samp0 && samp1;
  assign edge_any = edge0 || edge1;
  assign restart  = edge1 ? CNT_ONE : CNT_TWO;
  assign measured = edge1 ? cnt + CNT_ONE : cnt;
  assign n_eff    = (nper == '0) ? NPER_ONE : nper;
  assign ecnt_inc = ecnt + NPER_ONE;
  assign busy     = (state == MEASURE);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ecnt_next    = ecnt;
    nper_next    = nper;
    timeout_next = 1'b0;
    capture      = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: state_next = ARM;
        ARM: begin
          if (edge_any) begin
            cnt_next   = restart;
            ecnt_next  = '0;
            nper_next  = n_periods;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_any) begin
            if (ecnt_inc == n_eff) begin
              capture   = 1'b1;
              cnt_next  = restart;
              ecnt_next = '0;
            end else begin
              cnt_next  = cnt + CNT_TWO;
              ecnt_next = ecnt_inc;
            end
          end else if (cnt >= CNT_LIMIT) begin
            // Saturation reached without an edge: drop the partial count and rearm.
            timeout_next = 1'b1;
            state_next   = ARM;
          end else begin
            cnt_next = cnt + CNT_TWO;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      prev         <= 1'b0;
      cnt          <= '0;
      ecnt         <= '0;
      nper         <= '0;
      timeout      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      prev    <= samp1;
      cnt     <= cnt_next;
      ecnt    <= ecnt_next;
      nper    <= nper_next;
      timeout <= timeout_next;
      if (capture) begin
        result       <= measured;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (clr_overrun) begin
        overrun <= 1'b0;
      end else if (capture && result_valid && !result_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tone_period_meter.sv
// tb/tb_tone_period_meter.sv - scoreboard bench for tone_period_meter
module tb_tone_period_meter;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic        en8 = 1'b0;
  logic        samp0 = 1'b0;
  logic        samp1 = 1'b0;
  logic [7:0]  n_periods = 8'd1;
  logic        result_ready = 1'b1;
  logic        clr_overrun = 1'b0;

  logic [23:0] result;
  logic        result_valid, overrun, timeout, busy;
  logic [7:0]  result8;
  logic        valid8, overrun8, timeout8, busy8;

  int          total = 0;
  int          passed = 0;
  logic [23:0] exp_q[$];

  tone_period_meter #(.W_CNT(24), .W_NPER(8)) dut (
    .clock(clock), .resetb(resetb), .enable(enable), .samp0(samp0), .samp1(samp1),
    .n_periods(n_periods), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun), .clr_overrun(clr_overrun),
    .timeout(timeout), .busy(busy)
  );

  tone_period_meter #(.W_CNT(8), .W_NPER(8)) dut8 (
    .clock(clock), .resetb(resetb), .enable(en8), .samp0(samp0), .samp1(samp1),
    .n_periods(n_periods), .result(result8), .result_valid(valid8),
    .result_ready(result_ready), .overrun(overrun8), .clr_overrun(clr_overrun),
    .timeout(timeout8), .busy(busy8)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every accepted result is compared against the next expected value.
  always @(negedge clock) begin
    if (resetb && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got %0d expected none", result);
      end else begin
        check("result", {8'd0, result}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic wbit(input int s, input int start, input int high, input int period);
    return (s >= start) && (((s - start) % period) < high);
  endfunction

  task automatic step(input logic s0, input logic s1);
    samp0 = s0;
    samp1 = s1;
    @(posedge clock);
    #1;
  endtask

  task automatic run_wave(input int start, input int high, input int period, input int nclk);
    for (int k = 0; k < nclk; k++)
      step(wbit(2*k, start, high, period), wbit(2*k+1, start, high, period));
  endtask

  task automatic arm();
    enable = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) step(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    int at;

    repeat (2) @(posedge clock);
    #1;
    check("rst_result", {8'd0, result}, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    resetb = 1'b1;
    @(posedge clock);
    #1;

    // 1: n=1, 5 high / 5 low, first edge p=0
    n_periods = 8'd1;
    result_ready = 1'b1;
    repeat (3) exp_q.push_back(24'd10);
    arm();
    for (int k = 0; k < 16; k++) begin
      step(wbit(2*k, 0, 5, 10), wbit(2*k+1, 0, 5, 10));
      if (k == 4) check("t1_valid_before_2nd_edge", result_valid, 0);
      if (k == 5) check("t1_valid_at_2nd_edge", result_valid, 1);
    end
    idle(3);

    // 2: n=4, 4 high / 3 low, edges alternate p=0/p=1
    n_periods = 8'd4;
    repeat (3) exp_q.push_back(24'd28);
    arm();
    run_wave(0, 4, 7, 43);
    idle(3);

    // 3: W_CNT=8 timeout
    n_periods = 8'd1;
    en8 = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    pulses = 0;
    at = -1;
    for (int j = 1; j <= 130; j++) begin
      step(1'b0, 1'b0);
      if (timeout8) begin
        pulses++;
        at = j;
      end
      if (j == 126) check("t3_busy_before_timeout", busy8, 1);
    end
    check("t3_timeout_pulses", pulses, 1);
    check("t3_timeout_clock", at, 127);
    check("t3_busy_after_timeout", busy8, 0);
    check("t3_no_result", valid8, 0);
    en8 = 1'b0;
    step(1'b0, 1'b0);

    // 4: overrun with result_ready low, then clear
    n_periods = 8'd1;
    result_ready = 1'b0;
    exp_q.push_back(24'd10);
    arm();
    for (int k = 0; k < 11; k++) begin
      step(wbit(2*k, 0, 5, 10), wbit(2*k+1, 0, 5, 10));
      if (k == 5) check("t4_overrun_first", overrun, 0);
    end
    check("t4_overrun_set", overrun, 1);
    check("t4_result_held", {8'd0, result}, 10);
    enable = 1'b0;
    clr_overrun = 1'b1;
    step(1'b0, 1'b0);
    clr_overrun = 1'b0;
    check("t4_overrun_cleared", overrun, 0);
    check("t4_valid_kept", result_valid, 1);
    result_ready = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("t4_valid_accepted", result_valid, 0);

    // 5: abort mid-measure, then a fresh measurement
    arm();
    run_wave(0, 5, 10, 3);
    check("t5_busy_mid", busy, 1);
    idle(2);
    check("t5_busy_abort", busy, 0);
    check("t5_no_result", result_valid, 0);
    exp_q.push_back(24'd10);
    arm();
    run_wave(0, 5, 10, 6);
    idle(3);

    // 6: async reset with valid held, then n_periods=0 acts as 1
    result_ready = 1'b0;
    arm();
    run_wave(0, 5, 10, 8);
    check("t6_valid_pre", result_valid, 1);
    check("t6_busy_pre", busy, 1);
    resetb = 1'b0;
    #1;
    check("t6_rst_result", {8'd0, result}, 0);
    check("t6_rst_valid", result_valid, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_timeout", timeout, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clock);
    enable = 1'b0;
    samp0 = 1'b0;
    samp1 = 1'b0;
    resetb = 1'b1;
    n_periods = 8'd0;
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(24'd10);
    arm();
    run_wave(0, 5, 10, 6);
    idle(3);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
